result_reporter: RTL and testbench
==================================

Name: result_reporter

Overview:
Downstream consumer of the voting machine's four 8-bit per-candidate vote counters. On a close request it snapshots the counts and scans them to find the winner, tie status and total. It then streams a fixed 7-byte result frame over a valid/ready byte interface to the result link (UART/display serializer).

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame
CNT_W, 8, width of each candidate count (frame format requires 8)

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
close_req  input  1  request to publish results; sampled on clock edge
cand1_votes  input  CNT_W  candidate 1 count
cand2_votes  input  CNT_W  candidate 2 count
cand3_votes  input  CNT_W  candidate 3 count
cand4_votes  input  CNT_W  candidate 4 count
busy  output  1  high from close_req acceptance until return to IDLE
winner  output  2  winning candidate index, 0..3 = candidates 1..4
tie  output  1  more than one candidate holds the maximum
total  output  10  sum of the four snapshot counts
winner_valid  output  1  winner/tie/total are valid
tx_data  output  8  frame byte
tx_valid  output  1  tx_data valid
tx_ready  input  1  sink accepts byte when tx_valid & tx_ready at clock edge
done  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. busy, winner_valid, tx_valid, done, tie = 0. winner=0, total=0, tx_data=0. Snapshot registers cleared. Reset mid-frame aborts immediately. The sink sees tx_valid drop without completion.
- FSM states:
  - IDLE: on close_req=1 at edge N, capture the 4 counts into the snapshot, set busy=1, clear winner_valid, go to SCAN with idx=0.
  - SCAN: one candidate per cycle, idx 0..3 at edges N+1..N+4.
    - idx 0 loads max=c1, win=0, tie=0, sum=c1.
    - For later idx: if c > max, then max=c, win=idx, tie=0. If c == max, then tie=1 and win is unchanged. The lowest index wins ties.
    - sum accumulates in 10 bits with no overflow; the maximum is 1020.
  - After idx 3 go to SEND: at edge N+5, winner, tie and total are registered, winner_valid=1, tx_valid=1, tx_data=SYNC_BYTE.
  - SEND: bytes in order:
    - 0 SYNC_BYTE
    - 1 c1
    - 2 c2
    - 3 c3
    - 4 c4
    - 5 {tie, 5'b0, winner}
    - 6 checksum = (byte1+...+byte5) mod 256
  - Byte advance happens only on an edge with tx_valid & tx_ready. tx_data and tx_valid stay stable while tx_ready=0. tx_valid stays high between bytes (zero-bubble streaming is allowed).
  - On acceptance of byte 6: tx_valid=0, done=1 for exactly one cycle, busy=0, go to IDLE.
- winner_valid holds after the frame until the next close_req is accepted.
- close_req while busy=1 is ignored, with no queuing. A close_req held high at return to IDLE starts a new report on the next edge.
- Snapshot isolation: changes on cand*_votes after edge N do not affect the frame.
- All-zero counts: tie=1, winner=0, total=0.
- Minimum frame duration with tx_ready tied high: 5 cycles scan/setup + 7 byte cycles. The done pulse follows the last accept edge.

Decomposition:
- Shared package voting_pkg:
  - SYNC_BYTE default
  - FRAME_LEN=7
  - state enum IDLE/SCAN/SEND
  - byte index constants for the frame fields
  - TIE_BIT=7 position
- One natural sub-module, result_scan: snapshot, sequential max/tie/sum scan, registered winner/tie/total outputs.
- The top level holds the FSM and the frame byte mux/handshake.

Test Plan:
- Counts 10,20,5,1, close_req pulse, tx_ready=1:
  - winner=1, tie=0, total=36
  - frame A5,0A,14,05,01,01,25
  - done one cycle after the last byte
- Counts 3,7,2,7:
  - tie=1, winner=1
  - frame A5,03,07,02,07,81,94
- Counts 255 x4:
  - total=1020, tie=1, winner=0
  - frame A5,FF,FF,FF,FF,80,7C
- Backpressure: during byte 2, tx_ready=0 for 3 cycles:
  - tx_valid stays 1 and tx_data stays at the byte 2 value
  - the frame resumes unchanged, and exactly 7 accepts occur
- close_req pulsed again while busy, and counts changed mid-frame:
  - no second frame is produced
  - the frame contents match the first snapshot
- Reset driven low asynchronously during byte 4 (mid-frame):
  - all outputs are 0 immediately
  - after release, the next close_req produces a complete frame

Source files
------------

// File: rtl/voting_pkg.sv
// Shared constants and types for the election result reporter.
// Frame layout: sync, four candidate counts, tie/winner flags, additive checksum.
package voting_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CNT_W_DEF     = 8;
  localparam int         N_CAND        = 4;
  localparam int         FRAME_LEN     = 7;
  localparam int         TIE_BIT       = 7;

  localparam logic [2:0] BYTE_SYNC  = 3'd0;
  localparam logic [2:0] BYTE_C1    = 3'd1;
  localparam logic [2:0] BYTE_C2    = 3'd2;
  localparam logic [2:0] BYTE_C3    = 3'd3;
  localparam logic [2:0] BYTE_C4    = 3'd4;
  localparam logic [2:0] BYTE_FLAGS = 3'd5;
  localparam logic [2:0] BYTE_CSUM  = 3'd6;
  localparam logic [2:0] BYTE_LAST  = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } state_e;

  function automatic logic [7:0] flags_byte(input logic tie, input logic [1:0] winner);
    logic [7:0] b;
    b          = 8'h00;
    b[TIE_BIT] = tie;
    b[1:0]     = winner;
    return b;
  endfunction

endpackage

// File: rtl/result_reporter_if.sv
// Vote-count inputs, result outputs and the valid/ready byte link of the reporter.
// master = requester/sink side, slave = reporter side.
interface result_reporter_if #(
  parameter int CNT_W = 8
);

  logic             close_req;
  logic [CNT_W-1:0] cand1_votes;
  logic [CNT_W-1:0] cand2_votes;
  logic [CNT_W-1:0] cand3_votes;
  logic [CNT_W-1:0] cand4_votes;
  logic             busy;
  logic [1:0]       winner;
  logic             tie;
  logic [CNT_W+1:0] total;
  logic             winner_valid;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             done;

  modport master (
    output close_req, cand1_votes, cand2_votes, cand3_votes, cand4_votes, tx_ready,
    input  busy, winner, tie, total, winner_valid, tx_data, tx_valid, done
  );

  modport slave (
    input  close_req, cand1_votes, cand2_votes, cand3_votes, cand4_votes, tx_ready,
    output busy, winner, tie, total, winner_valid, tx_data, tx_valid, done
  );

endinterface

// File: rtl/result_scan.sv
// Snapshots the four counts, scans one candidate per cycle for max/tie/sum, then registers results.
// Latency: 4 scan cycles + 1 commit cycle after start; no backpressure, runs to completion once started.
module result_scan
  import voting_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CNT_W-1:0]             cand1_votes,
  input  logic [CNT_W-1:0]             cand2_votes,
  input  logic [CNT_W-1:0]             cand3_votes,
  input  logic [CNT_W-1:0]             cand4_votes,
  output logic [N_CAND-1:0][CNT_W-1:0] snap,
  output logic                         scan_done,
  output logic [1:0]                   winner,
  output logic                         tie,
  output logic [CNT_W+1:0]             total,
  output logic                         winner_valid
);

  logic             running;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] max_q;
  logic [1:0]       win_q;
  logic             tie_q;
  logic [CNT_W+1:0] sum_q;

  assign cur       = snap[idx[1:0]];
  assign scan_done = running && (idx == 3'd4);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap    <= '0;
      running <= 1'b0;
      idx     <= 3'd0;
    end else if (start) begin
      snap    <= {cand4_votes, cand3_votes, cand2_votes, cand1_votes};
      running <= 1'b1;
      idx     <= 3'd0;
    end else if (running) begin
      if (scan_done) running <= 1'b0;
      else           idx     <= idx + 3'd1;
    end
  end

  // Strict '>' keeps the lowest index on ties; a later larger count clears the tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      max_q <= '0;
      win_q <= 2'd0;
      tie_q <= 1'b0;
      sum_q <= '0;
    end else if (running && !scan_done) begin
      if (idx == 3'd0) begin
        max_q <= cur;
        win_q <= 2'd0;
        tie_q <= 1'b0;
        sum_q <= {2'b00, cur};
      end else begin
        sum_q <= sum_q + {2'b00, cur};
        if (cur > max_q) begin
          max_q <= cur;
          win_q <= idx[1:0];
          tie_q <= 1'b0;
        end else if (cur == max_q) begin
          tie_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      winner       <= 2'd0;
      tie          <= 1'b0;
      total        <= '0;
      winner_valid <= 1'b0;
    end else if (start) begin
      winner_valid <= 1'b0;
    end else if (scan_done) begin
      winner       <= win_q;
      tie          <= tie_q;
      total        <= sum_q;
      winner_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/result_reporter.sv
// Publishes election results: snapshot + scan, then a 7-byte frame over a valid/ready byte link.
// Latency: first byte valid 5 cycles after close_req; bytes held stable while tx_ready is low.
module result_reporter
  import voting_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         CNT_W     = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  result_reporter_if.slave bus
);

  state_e                      state_q;
  state_e                      state_d;
  logic [2:0]                  byte_idx_q;
  logic                        done_q;
  logic                        start;
  logic                        accept;
  logic                        last_accept;
  logic                        scan_done;
  logic [N_CAND-1:0][CNT_W-1:0] snap;
  logic [1:0]                  winner;
  logic                        tie;
  logic [CNT_W+1:0]            total;
  logic                        winner_valid;
  logic                        tx_valid;
  logic [7:0]                  tx_data;
  logic [7:0]                  flags;
  logic [7:0]                  csum;

  assign start       = (state_q == IDLE) && bus.close_req;
  assign accept      = tx_valid && bus.tx_ready;
  assign last_accept = accept && (byte_idx_q == BYTE_LAST);

  result_scan #(
    .CNT_W (CNT_W)
  ) u_scan (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .cand1_votes  (bus.cand1_votes),
    .cand2_votes  (bus.cand2_votes),
    .cand3_votes  (bus.cand3_votes),
    .cand4_votes  (bus.cand4_votes),
    .snap         (snap),
    .scan_done    (scan_done),
    .winner       (winner),
    .tie          (tie),
    .total        (total),
    .winner_valid (winner_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.close_req) state_d = SCAN;
      SCAN:    if (scan_done)     state_d = SEND;
      SEND:    if (last_accept)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_idx_q <= 3'd0;
      done_q     <= 1'b0;
    end else begin
      done_q <= last_accept;
      if (state_q != SEND || last_accept) byte_idx_q <= 3'd0;
      else if (accept)                    byte_idx_q <= byte_idx_q + 3'd1;
    end
  end

  // Flags and checksum come from the snapshot, so late count changes never reach the frame.
  assign flags = flags_byte(tie, winner);
  assign csum  = 8'(snap[0]) + 8'(snap[1]) + 8'(snap[2]) + 8'(snap[3]) + flags;

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    if (state_q == SEND) begin
      tx_valid = 1'b1;
      case (byte_idx_q)
        BYTE_SYNC:  tx_data = SYNC_BYTE;
        BYTE_C1:    tx_data = 8'(snap[0]);
        BYTE_C2:    tx_data = 8'(snap[1]);
        BYTE_C3:    tx_data = 8'(snap[2]);
        BYTE_C4:    tx_data = 8'(snap[3]);
        BYTE_FLAGS: tx_data = flags;
        BYTE_CSUM:  tx_data = csum;
        default:    tx_data = 8'h00;
      endcase
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.tx_valid     = tx_valid;
  assign bus.tx_data      = tx_data;
  assign bus.winner       = winner;
  assign bus.tie          = tie;
  assign bus.total        = total;
  assign bus.winner_valid = winner_valid;

endmodule

// File: tb/tb_result_reporter.sv
// Randomized and directed checks of result_reporter against a queue-based frame model.
module tb_result_reporter;
  import voting_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fails;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  result_reporter_if #(.CNT_W(8)) bus ();

  result_reporter #(
    .SYNC_BYTE (8'hA5),
    .CNT_W     (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: winner is the first candidate holding the maximum, tie if several hold it.
  task automatic model(input logic [7:0] c[4], output logic [1:0] w, output logic t,
                       output logic [9:0] tot, output byte_q_t fr);
    int mx;
    int nmax;
    int sum;
    int flags;
    mx   = -1;
    nmax = 0;
    sum  = 0;
    w    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      sum += int'(c[i]);
      if (int'(c[i]) > mx) mx = int'(c[i]);
    end
    for (int i = 3; i >= 0; i--) begin
      if (int'(c[i]) == mx) begin
        w = 2'(i);
        nmax++;
      end
    end
    t     = (nmax > 1);
    tot   = 10'(sum);
    flags = (t ? 128 : 0) + int'(w);
    fr    = {};
    fr.push_back(8'hA5);
    for (int i = 0; i < 4; i++) fr.push_back(c[i]);
    fr.push_back(8'(flags));
    fr.push_back(8'((sum + flags) % 256));
  endtask

  task automatic drive_counts(input logic [7:0] c[4]);
    bus.cand1_votes = c[0];
    bus.cand2_votes = c[1];
    bus.cand3_votes = c[2];
    bus.cand4_votes = c[3];
  endtask

  task automatic drive_random_counts();
    bus.cand1_votes = 8'($urandom);
    bus.cand2_votes = 8'($urandom);
    bus.cand3_votes = 8'($urandom);
    bus.cand4_votes = 8'($urandom);
  endtask

  // mode 0: always ready, 1: random ready, 2: three stall cycles on byte 2.
  task automatic run_report(input logic [7:0] c[4], input int mode, input bit poke, input string name);
    logic [1:0] ew;
    logic       et;
    logic [9:0] etot;
    byte_q_t    exp_fr;
    byte_q_t    got_fr;
    int         lat;
    int         cyc;
    int         stall;
    bit         prev_stall;
    bit         poked;
    logic [7:0] prev_d;
    logic       v;
    logic [7:0] d;
    bit         r;
    logic [7:0] gb;

    model(c, ew, et, etot, exp_fr);
    @(negedge clock);
    drive_counts(c);
    bus.close_req = 1'b1;
    @(negedge clock);
    bus.close_req = 1'b0;
    check($sformatf("%s_busy", name), bus.busy, 1);
    check($sformatf("%s_wv_clr", name), bus.winner_valid, 0);
    if (poke) drive_random_counts();

    lat = 0;
    while (!bus.tx_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check($sformatf("%s_latency", name), lat, 5);
    check($sformatf("%s_winner", name), bus.winner, ew);
    check($sformatf("%s_tie", name), bus.tie, et);
    check($sformatf("%s_total", name), bus.total, etot);
    check($sformatf("%s_wv", name), bus.winner_valid, 1);

    got_fr     = {};
    cyc        = 0;
    stall      = 0;
    prev_stall = 1'b0;
    poked      = 1'b0;
    prev_d     = 8'h00;
    while (got_fr.size() < 7 && cyc < 300) begin
      v = bus.tx_valid;
      d = bus.tx_data;
      if (prev_stall) begin
        check($sformatf("%s_hold_valid", name), v, 1);
        check($sformatf("%s_hold_data", name), d, prev_d);
      end
      r = 1'b1;
      if (mode == 1) r = ($urandom_range(0, 2) != 0);
      if (mode == 2 && got_fr.size() == 2 && stall < 3) begin
        r = 1'b0;
        stall++;
      end
      if (poke && !poked && got_fr.size() == 3) begin
        bus.close_req = 1'b1;
        drive_random_counts();
        poked = 1'b1;
      end else begin
        bus.close_req = 1'b0;
      end
      bus.tx_ready = r;
      if (v && r) got_fr.push_back(d);
      prev_stall = v && !r;
      prev_d     = d;
      @(negedge clock);
      cyc++;
    end
    bus.close_req = 1'b0;
    check($sformatf("%s_done", name), bus.done, 1);
    check($sformatf("%s_busy_end", name), bus.busy, 0);
    check($sformatf("%s_valid_end", name), bus.tx_valid, 0);
    check($sformatf("%s_nbytes", name), got_fr.size(), 7);
    for (int i = 0; i < 7; i++) begin
      gb = (i < got_fr.size()) ? got_fr[i] : 8'hxx;
      check($sformatf("%s_byte%0d", name, i), gb, exp_fr[i]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("%s_done_pulse", name), bus.done, 0);
      check($sformatf("%s_no_refire", name), bus.busy, 0);
      check($sformatf("%s_no_frame", name), bus.tx_valid, 0);
    end
    check($sformatf("%s_wv_hold", name), bus.winner_valid, 1);
    check($sformatf("%s_total_hold", name), bus.total, etot);
  endtask

  task automatic reset_mid_frame();
    logic [7:0] c[4];
    int         lat;
    c = '{8'd9, 8'd4, 8'd9, 8'd1};
    @(negedge clock);
    drive_counts(c);
    bus.close_req = 1'b1;
    @(negedge clock);
    bus.close_req = 1'b0;
    lat = 0;
    while (!bus.tx_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("rst_latency", lat, 5);
    bus.tx_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("rst_pre_byte4", bus.tx_data, 8'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.tx_valid, 0);
    check("rst_data", bus.tx_data, 0);
    check("rst_wv", bus.winner_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_tie", bus.tie, 0);
    check("rst_winner", bus.winner, 0);
    check("rst_total", bus.total, 0);
    bus.tx_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c[4];
    n_checks        = 0;
    n_fails         = 0;
    bus.close_req   = 1'b0;
    bus.tx_ready    = 1'b0;
    bus.cand1_votes = 8'd0;
    bus.cand2_votes = 8'd0;
    bus.cand3_votes = 8'd0;
    bus.cand4_votes = 8'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #20;
    check("reset_busy", bus.busy, 0);
    check("reset_valid", bus.tx_valid, 0);
    check("reset_data", bus.tx_data, 0);
    check("reset_done", bus.done, 0);
    check("reset_wv", bus.winner_valid, 0);
    check("reset_tie", bus.tie, 0);
    check("reset_winner", bus.winner, 0);
    check("reset_total", bus.total, 0);
    @(negedge clock);
    reset = 1'b1;

    c = '{8'd10, 8'd20, 8'd5, 8'd1};     run_report(c, 0, 1'b0, "basic");
    c = '{8'd3, 8'd7, 8'd2, 8'd7};       run_report(c, 0, 1'b0, "tie");
    c = '{8'd255, 8'd255, 8'd255, 8'd255}; run_report(c, 0, 1'b0, "maxed");
    c = '{8'd0, 8'd0, 8'd0, 8'd0};       run_report(c, 0, 1'b0, "zeros");
    c = '{8'd10, 8'd20, 8'd5, 8'd1};     run_report(c, 2, 1'b0, "stall");
    c = '{8'd40, 8'd41, 8'd99, 8'd98};   run_report(c, 0, 1'b1, "busy_poke");

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++)
        c[i] = (k % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      run_report(c, 1, (k % 4 == 3), $sformatf("rand%0d", k));
    end

    reset_mid_frame();
    c = '{8'd77, 8'd12, 8'd200, 8'd3};   run_report(c, 0, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
